// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch sequencer.
// Owns the PC, drives the single-port instruction BRAM address (1-cycle
// registered read) and presents instruction/PC pairs to decode with
// valid/ready handshaking, halt/resume and branch redirects.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating stall and
// redirect counters (stall_cnt, redir_cnt).

module fetch_sequencer #(
  parameter int            AW       = 12,
  parameter logic [AW-1:0] RESET_PC = 12'd1,
  parameter logic [AW-1:0] START_PC = 12'd4,
  localparam int           INST_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_vld,
  input  logic [AW-1:0]     redirect_pc,
  input  logic              dec_ready,
  output logic [AW-1:0]     mem_addr,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [AW-1:0]     if_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       redir_cnt,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic          live_q;
  logic          in_run;
  logic          redirect_run;
  logic          accept;

  assign in_run       = (state_q == RUN);
  assign redirect_run = redirect_vld & in_run;

  // Decode sees the BRAM output directly; pc_q always names the word that
  // the BRAM is currently holding, so if_pc and if_inst travel together.
  assign if_valid = in_run & live_q;
  assign if_inst  = mem_rdata;
  assign if_pc    = pc_q;
  assign busy     = (state_q != IDLE);

  // A redirect squashes the presented instruction even when decode is ready.
  assign accept = if_valid & dec_ready & ~redirect_vld;

  // Address selection: re-issuing pc_q during a stall keeps mem_rdata stable.
  always_comb begin
    mem_addr = pc_q;
    if (redirect_run) begin
      mem_addr = redirect_pc;
    end else if ((state_q == IDLE) && start) begin
      mem_addr = START_PC;
    end else if (accept) begin
      mem_addr = pc_q + AW'(1);
    end
  end

  // Fetch FSM: tracks the issued PC and whether the BRAM holds its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      live_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            pc_q    <= mem_addr;
            live_q  <= 1'b1;
          end
        end
        RUN: begin
          pc_q <= mem_addr;
          if (halt) begin
            state_q <= HALTED;
            live_q  <= 1'b0;
          end else begin
            live_q  <= 1'b1;
          end
        end
        HALTED: begin
          if (redirect_vld) begin
            pc_q <= redirect_pc;
          end else if (start) begin
            state_q <= RUN;
            pc_q    <= mem_addr;
            live_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          pc_q    <= RESET_PC;
          live_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating performance counters for back-pressure and taken redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
      redir_cnt <= 16'h0000;
    end else begin
      if (if_valid && !dec_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'h0001;
      end
      if (redirect_run && (redir_cnt != 16'hFFFF)) begin
        redir_cnt <= redir_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule
